// File: rtl/regsrc2_pkg.sv
// Shared encodings and control-word bundle for the register-source-2 micro-sequencer.
package regsrc2_pkg;

  // Operand mux select encodings
  localparam logic [2:0] SEL_IN1     = 3'd0;
  localparam logic [2:0] SEL_TWO     = 3'd1;
  localparam logic [2:0] SEL_FOUR    = 3'd2;
  localparam logic [2:0] SEL_FIFTEEN = 3'd3;
  localparam logic [2:0] SEL_IN2     = 3'd4;

  // Micro-op codes presented by the decoder
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_SHR15 = 3'd4;
  localparam logic [2:0] OP_ADDW  = 3'd5;

  // ALU operation encodings
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_SHR  = 2'b11;

  // Sequencer states
  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // Everything the datapath sees for one step
  typedef struct packed {
    logic [2:0] sel;
    logic [1:0] alu;
    logic       sp_we;
    logic       rf_we;
    logic       mem_we;
    logic       mem_re;
    logic       pc_we;
  } ctrl_word_t;

  // Quiet control word driven while idle or after an illegal op
  localparam ctrl_word_t CTRL_IDLE = '0;

  // Codes 6 and 7 have no micro-program
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_ADDW);
  endfunction

endpackage

// File: rtl/regsrc2_ucode_rom.sv
// Combinational micro-code table: (op, step) -> control word, last-step flag, illegal flag.
module regsrc2_ucode_rom
  import regsrc2_pkg::*;
#(
  parameter int STEP_W = 2
) (
  input  logic [2:0]        i_op,
  input  logic [STEP_W-1:0] i_step,
  output ctrl_word_t        o_ctrl,
  output logic              o_last,
  output logic              o_illegal
);

  logic w_step0;
  logic w_step1;

  assign w_step0 = (i_step == STEP_W'(0));
  assign w_step1 = (i_step == STEP_W'(1));

  // Look up the control word for one step; out-of-range steps read as a quiet final step
  always_comb begin
    o_ctrl    = CTRL_IDLE;
    o_last    = 1'b1;
    o_illegal = !op_is_legal(i_op);
    case (i_op)
      OP_NOP: begin
        o_ctrl.sel = SEL_IN1;
        o_ctrl.alu = ALU_PASS;
      end
      OP_PUSH: begin
        o_last = !w_step0;
        if (w_step0) begin
          o_ctrl.sel   = SEL_TWO;
          o_ctrl.alu   = ALU_SUB;
          o_ctrl.sp_we = 1'b1;
        end else if (w_step1) begin
          o_ctrl.sel    = SEL_IN2;
          o_ctrl.alu    = ALU_PASS;
          o_ctrl.mem_we = 1'b1;
        end
      end
      OP_POP: begin
        o_last = !w_step0;
        if (w_step0) begin
          o_ctrl.sel    = SEL_IN2;
          o_ctrl.alu    = ALU_PASS;
          o_ctrl.mem_re = 1'b1;
          o_ctrl.rf_we  = 1'b1;
        end else if (w_step1) begin
          o_ctrl.sel   = SEL_TWO;
          o_ctrl.alu   = ALU_ADD;
          o_ctrl.sp_we = 1'b1;
        end
      end
      OP_CALL: begin
        o_last = !(w_step0 || w_step1);
        if (w_step0) begin
          o_ctrl.sel   = SEL_TWO;
          o_ctrl.alu   = ALU_SUB;
          o_ctrl.sp_we = 1'b1;
        end else if (w_step1) begin
          o_ctrl.sel    = SEL_IN2;
          o_ctrl.alu    = ALU_PASS;
          o_ctrl.mem_we = 1'b1;
        end else if (i_step == STEP_W'(2)) begin
          o_ctrl.sel   = SEL_IN1;
          o_ctrl.alu   = ALU_PASS;
          o_ctrl.pc_we = 1'b1;
        end
      end
      OP_SHR15: begin
        o_ctrl.sel   = SEL_FIFTEEN;
        o_ctrl.alu   = ALU_SHR;
        o_ctrl.rf_we = 1'b1;
      end
      OP_ADDW: begin
        o_ctrl.sel   = SEL_FOUR;
        o_ctrl.alu   = ALU_ADD;
        o_ctrl.rf_we = 1'b1;
      end
      default: begin
        o_ctrl = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/regsrc2_sequencer.sv
// Micro-sequencer stepping compound instructions through the register-source-2 operand mux.
module regsrc2_sequencer
  import regsrc2_pkg::*;
#(
  parameter int STEP_W = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start_valid,
  output logic       o_start_ready,
  input  logic [2:0] i_op,
  input  logic       i_hold,
  output logic [2:0] o_sel,
  output logic [1:0] o_alu_op,
  output logic       o_sp_we,
  output logic       o_rf_we,
  output logic       o_mem_we,
  output logic       o_mem_re,
  output logic       o_pc_we,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  state_t            r_state;
  logic [2:0]        r_op;
  logic [STEP_W-1:0] r_step;
  ctrl_word_t        r_ctrl;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_stall;
  logic [2:0]        w_romOp;
  logic [STEP_W-1:0] w_romStep;
  ctrl_word_t        w_romCtrl;
  logic              w_romLast;
  logic              w_romIllegal;

  // r_done is high exactly while the current RUN step is the final one
  assign o_start_ready = (r_state == ST_IDLE) || ((r_state == ST_RUN) && r_done && !i_hold);
  assign w_accept      = i_start_valid && o_start_ready;
  assign w_stall       = (r_state == ST_RUN) && i_hold;

  // The ROM is addressed with the step that will be shown next cycle
  assign w_romOp   = w_accept ? i_op : r_op;
  assign w_romStep = w_accept ? STEP_W'(0) : (r_step + STEP_W'(1));

  regsrc2_ucode_rom #(
    .STEP_W (STEP_W)
  ) u_rom (
    .i_op      (w_romOp),
    .i_step    (w_romStep),
    .o_ctrl    (w_romCtrl),
    .o_last    (w_romLast),
    .o_illegal (w_romIllegal)
  );

  // Sequencer FSM: accept, advance, stall or retire, registering the next step's control word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_step  <= '0;
      r_ctrl  <= CTRL_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (!w_stall) begin
        if (w_accept) begin
          r_step <= '0;
          if (w_romIllegal) begin
            r_state <= ST_IDLE;
            r_ctrl  <= CTRL_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_op    <= i_op;
            r_ctrl  <= w_romCtrl;
            r_busy  <= 1'b1;
            r_done  <= w_romLast;
          end
        end else if ((r_state == ST_RUN) && !r_done) begin
          r_step <= w_romStep;
          r_ctrl <= w_romCtrl;
          r_done <= w_romLast;
        end else begin
          r_state <= ST_IDLE;
          r_step  <= '0;
          r_ctrl  <= CTRL_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      end
    end
  end

  assign o_sel    = r_ctrl.sel;
  assign o_alu_op = r_ctrl.alu;
  assign o_sp_we  = r_ctrl.sp_we;
  assign o_rf_we  = r_ctrl.rf_we;
  assign o_mem_we = r_ctrl.mem_we;
  assign o_mem_re = r_ctrl.mem_re;
  assign o_pc_we  = r_ctrl.pc_we;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_err    = r_err;

endmodule

// File: tb/tb_regsrc2_sequencer.sv
// Scoreboard bench for regsrc2_sequencer: each driven cycle queues the outputs expected after the edge.
module tb_regsrc2_sequencer;

  logic       clk;
  logic       rst_n;
  logic       startValid;
  logic       startReady;
  logic [2:0] op;
  logic       hold;
  logic [2:0] sel;
  logic [1:0] aluOp;
  logic       spWe, rfWe, memWe, memRe, pcWe;
  logic       busy, done, err;

  int checkCount = 0;
  int passCount  = 0;

  logic [12:0] scoreQ[$];

  // Strobe bit masks in {sp, rf, mem_we, mem_re, pc} order
  localparam logic [4:0] S0 = 5'b00000;
  localparam logic [4:0] SP = 5'b10000;
  localparam logic [4:0] RF = 5'b01000;
  localparam logic [4:0] MW = 5'b00100;
  localparam logic [4:0] MR = 5'b00010;
  localparam logic [4:0] PC = 5'b00001;
  localparam logic [12:0] IDLEV = 13'd0;

  regsrc2_sequencer #(.STEP_W(2)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start_valid (startValid),
    .o_start_ready (startReady),
    .i_op          (op),
    .i_hold        (hold),
    .o_sel         (sel),
    .o_alu_op      (aluOp),
    .o_sp_we       (spWe),
    .o_rf_we       (rfWe),
    .o_mem_we      (memWe),
    .o_mem_re      (memRe),
    .o_pc_we       (pcWe),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs an expected output vector as {busy, done, err, sel, alu, strobes}
  function automatic logic [12:0] mk(input logic [2:0] s, input logic [1:0] a,
                                     input logic [4:0] stb, input logic b,
                                     input logic d, input logic e);
    return {b, d, e, s, a, stb};
  endfunction

  function automatic logic [12:0] observed();
    return {busy, done, err, sel, aluOp, spWe, rfWe, memWe, memRe, pcWe};
  endfunction

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one cycle, check the combinational ready, queue and then verify the post-edge outputs
  task automatic applyStimulus(input string tag, input logic v, input logic [2:0] o,
                               input logic h, input logic expReady, input logic [12:0] expOut);
    logic [12:0] exp;
    startValid = v;
    op         = o;
    hold       = h;
    #1;
    checkOutput({tag, ".ready"}, {12'd0, startReady}, {12'd0, expReady});
    scoreQ.push_back(expOut);
    @(posedge clk);
    #1;
    if (scoreQ.size() == 0) begin
      checkOutput({tag, ".queue"}, 13'd1, 13'd0);
    end else begin
      exp = scoreQ.pop_front();
      checkOutput(tag, observed(), exp);
    end
    @(negedge clk);
  endtask

  initial begin
    startValid = 1'b0;
    op         = 3'd0;
    hold       = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset.outs", observed(), IDLEV);
    checkOutput("reset.ready", {12'd0, startReady}, 13'd1);

    // PUSH: two steps then idle
    applyStimulus("push.s0",   1, 3'd1, 0, 1, mk(3'd1, 2'b10, SP, 1, 0, 0));
    applyStimulus("push.s1",   0, 3'd0, 0, 0, mk(3'd4, 2'b00, MW, 1, 1, 0));
    applyStimulus("push.idle", 0, 3'd0, 0, 1, IDLEV);

    // CALL with a two-cycle hold on step 1 and a one-cycle hold on the final step
    applyStimulus("call.s0",   1, 3'd3, 0, 1, mk(3'd1, 2'b10, SP, 1, 0, 0));
    applyStimulus("call.s1",   0, 3'd0, 0, 0, mk(3'd4, 2'b00, MW, 1, 0, 0));
    applyStimulus("call.h1a",  0, 3'd0, 1, 0, mk(3'd4, 2'b00, MW, 1, 0, 0));
    applyStimulus("call.h1b",  0, 3'd0, 1, 0, mk(3'd4, 2'b00, MW, 1, 0, 0));
    applyStimulus("call.s2",   0, 3'd0, 0, 0, mk(3'd0, 2'b00, PC, 1, 1, 0));
    applyStimulus("call.h2",   1, 3'd5, 1, 0, mk(3'd0, 2'b00, PC, 1, 1, 0));
    applyStimulus("call.idle", 0, 3'd0, 0, 1, IDLEV);

    // POP then SHR15 back-to-back with start_valid held high
    applyStimulus("pop.s0",    1, 3'd2, 0, 1, mk(3'd4, 2'b00, MR | RF, 1, 0, 0));
    applyStimulus("pop.s1",    1, 3'd4, 0, 0, mk(3'd1, 2'b01, SP, 1, 1, 0));
    applyStimulus("shr.s0",    1, 3'd4, 0, 1, mk(3'd3, 2'b11, RF, 1, 1, 0));
    applyStimulus("shr.idle",  0, 3'd0, 0, 1, IDLEV);

    // Illegal op 6 from IDLE, then ADDW accepted during the err cycle
    applyStimulus("ill6.err",  1, 3'd6, 0, 1, mk(3'd0, 2'b00, S0, 0, 0, 1));
    applyStimulus("addw.s0",   1, 3'd5, 0, 1, mk(3'd2, 2'b01, RF, 1, 1, 0));
    applyStimulus("addw.idle", 0, 3'd0, 0, 1, IDLEV);

    // NOP, then illegal op 7 accepted on its final step
    applyStimulus("nop.s0",    1, 3'd0, 0, 1, mk(3'd0, 2'b00, S0, 1, 1, 0));
    applyStimulus("ill7.err",  1, 3'd7, 0, 1, mk(3'd0, 2'b00, S0, 0, 0, 1));
    applyStimulus("ill7.idle", 0, 3'd0, 0, 1, IDLEV);

    // Reset during CALL step 1 aborts asynchronously
    applyStimulus("abort.s0",  1, 3'd3, 0, 1, mk(3'd1, 2'b10, SP, 1, 0, 0));
    applyStimulus("abort.s1",  0, 3'd0, 0, 0, mk(3'd4, 2'b00, MW, 1, 0, 0));
    rst_n = 1'b0;
    #1;
    checkOutput("abort.async", observed(), IDLEV);
    checkOutput("abort.ready", {12'd0, startReady}, 13'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post.s0",   1, 3'd1, 0, 1, mk(3'd1, 2'b10, SP, 1, 0, 0));
    applyStimulus("post.s1",   0, 3'd0, 0, 0, mk(3'd4, 2'b00, MW, 1, 1, 0));
    applyStimulus("post.idle", 0, 3'd0, 0, 1, IDLEV);

    checkOutput("queue.empty", {12'd0, scoreQ.size() != 0}, 13'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
